qu_rob: RTL and testbench
=========================

QU_ROB -- requirements
Module: qu_rob

Interface
REQ-001 SHALL have parameter DEPTH, default ROB_DEPTH (8): number of reorder-buffer entries, a power of two.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alloc_valid  input  1  dispatch requests a new entry.
REQ-005 SHALL have port alloc_dest  input  PHY_RF_ADDR_WIDTH  physical destination register of the new entry.
REQ-006 SHALL have port alloc_ready  output  1  an entry is free; high when count < DEPTH.
REQ-007 SHALL have port alloc_addr  output  ROB_ADDR_WIDTH  index (tail) assigned on alloc handshake.
REQ-008 SHALL have ports issue_valid  input  1 and issue_addr  input  ROB_ADDR_WIDTH: entry sent to a functional unit.
REQ-009 SHALL have ports wb_valid  input  1, wb_addr  input  ROB_ADDR_WIDTH and wb_value  input  32: result writeback.
REQ-010 SHALL have ports commit_valid  output  1, commit_ready  input  1, commit_dest  output  PHY_RF_ADDR_WIDTH, commit_value  output  32: in-order commit handshake.
REQ-011 SHALL have ports rd_addr  input  ROB_ADDR_WIDTH, rd_state  output  2, rd_value  output  32: combinational operand lookup.
REQ-012 SHALL have ports flush  input  1 (discard all entries), count  output  ROB_ADDR_WIDTH+1, empty  output  1.

Function
REQ-013 SHALL hold DEPTH entries of type rob_cell_t (value, dest, state) plus head pointer, tail pointer and occupancy count.
REQ-014 Entry states: EMPTY -> PENDING (alloc) -> EXECUTE (issue) -> RETIRED (writeback, result valid) -> EMPTY (commit or flush).
REQ-015 Alloc handshake = alloc_valid & alloc_ready; on it entry[tail] <= {value 0, alloc_dest, PENDING}, tail <= tail+1 modulo DEPTH; alloc_addr = tail combinationally.
REQ-016 alloc_ready SHALL depend only on registered count; when full, no alloc is accepted even if a commit occurs in the same cycle.
REQ-017 issue_valid SHALL move entry[issue_addr] PENDING -> EXECUTE; in any other state it SHALL be ignored.
REQ-018 wb_valid SHALL write wb_value and set RETIRED if entry[wb_addr] is PENDING or EXECUTE; writeback to EMPTY or RETIRED SHALL be ignored.
REQ-019 commit_valid SHALL be high exactly when entry[head].state == RETIRED; commit_dest/commit_value driven combinationally from entry[head].
REQ-020 Commit handshake = commit_valid & commit_ready; entry[head] <= EMPTY, head <= head+1 modulo DEPTH.
REQ-021 count SHALL be +1 on alloc only, -1 on commit only, unchanged on both; empty = (count == 0).
REQ-022 Latency: alloc at edge N -> PENDING visible cycle N+1; wb at edge N to head -> commit_valid in cycle N+1; no bypass in the same cycle.
REQ-023 issue and wb to the same index in one cycle: wb wins (RETIRED).
REQ-024 wb and commit in one cycle to different entries SHALL both take effect; wb to the tail being allocated in the same cycle SHALL be ignored.
REQ-025 rd_state/rd_value SHALL reflect registered entry[rd_addr] with no forwarding of same-cycle wb.
REQ-026 flush SHALL override all other inputs: every entry EMPTY, head = tail = 0, count = 0 at the next edge.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 without gaps; full is distinguished from empty by count, not by pointer equality.

Reset
REQ-028 rst_n low SHALL asynchronously set all entries {0, 0, EMPTY}, head = tail = count = 0.
REQ-029 During reset: alloc_ready = 1, alloc_addr = 0, commit_valid = 0, commit_dest = 0, commit_value = 0, empty = 1, count = 0, rd_state = EMPTY, rd_value = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries; no commit is produced for them after release.

Structure
REQ-031 ROB_DEPTH, ROB_ADDR_WIDTH, rob_addr_t, rob_cell_t and ROB_STATE_* SHALL come from package qu_common; no new local typedefs.
REQ-032 SHALL be a single module with no sub-modules; entry array and pointers in one always_ff block.

Verification
REQ-033 Fill: 8 allocs (dest 1..8) with commit_ready=0 -> alloc_addr 0..7, count 8, alloc_ready 0; 9th alloc_valid not accepted.
REQ-034 Out-of-order wb: alloc 3, wb index 2 (value 0xC), then 1, then 0 -> commit_valid only after index 0 wb; commits in order 0,1,2 with correct dest/value.
REQ-035 Full + commit same cycle: count 8, commit handshake with alloc_valid=1 -> no alloc, count 7; alloc next cycle -> count 8, tail wraps to 0.
REQ-036 Wrap-around: 20 alloc/wb/commit cycles -> head/tail wrap 7->0, commit order and values preserved, count never exceeds 8.
REQ-037 Flush with 5 live entries plus simultaneous alloc and wb -> next cycle count 0, empty 1, all rd_state EMPTY, alloc_addr 0.
REQ-038 Async reset asserted between clock edges with 4 entries RETIRED -> outputs reach reset values immediately; commit_valid 0 after release.

Source files
------------

// File: rtl/qu_common.sv
// Shared reorder-buffer definitions: geometry, entry encoding and cell layout.
package qu_common;

    localparam int ROB_DEPTH         = 8;
    localparam int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH);
    localparam int PHY_RF_ADDR_WIDTH = 6;

    typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;

    // Entry lifecycle: EMPTY -> PENDING -> EXECUTE -> RETIRED -> EMPTY.
    localparam logic [1:0] ROB_STATE_EMPTY   = 2'd0;
    localparam logic [1:0] ROB_STATE_PENDING = 2'd1;
    localparam logic [1:0] ROB_STATE_EXECUTE = 2'd2;
    localparam logic [1:0] ROB_STATE_RETIRED = 2'd3;

    typedef struct packed {
        logic [31:0]                  value;
        logic [PHY_RF_ADDR_WIDTH-1:0] dest;
        logic [1:0]                   state;
    } rob_cell_t;

endpackage : qu_common

// File: rtl/qu_rob.sv
// Reorder buffer: in-order allocate, out-of-order issue/writeback, in-order commit.
// A circular array addressed by head (oldest) and tail (next free); the
// occupancy count, not pointer equality, tells full from empty.
module qu_rob
    import qu_common::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_dest,
    output logic                         alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]    alloc_addr,
    input  logic                         issue_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]    issue_addr,
    input  logic                         wb_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]    wb_addr,
    input  logic [31:0]                  wb_value,
    output logic                         commit_valid,
    input  logic                         commit_ready,
    output logic [PHY_RF_ADDR_WIDTH-1:0] commit_dest,
    output logic [31:0]                  commit_value,
    input  logic [ROB_ADDR_WIDTH-1:0]    rd_addr,
    output logic [1:0]                   rd_state,
    output logic [31:0]                  rd_value,
    input  logic                         flush,
    output logic [ROB_ADDR_WIDTH:0]      count,
    output logic                         empty
);

    localparam logic [ROB_ADDR_WIDTH:0] FULL_COUNT = (ROB_ADDR_WIDTH + 1)'(DEPTH);
    localparam rob_addr_t               LAST_IDX   = rob_addr_t'(DEPTH - 1);

    rob_cell_t               entries_q [DEPTH];
    rob_cell_t               entries_d [DEPTH];
    rob_addr_t               head_q, head_d;
    rob_addr_t               tail_q, tail_d;
    logic [ROB_ADDR_WIDTH:0] count_q, count_d;

    logic      alloc_fire;
    logic      commit_fire;
    rob_cell_t head_cell;
    rob_cell_t rd_cell;

    // Handshakes and registered-state views; everything here reads only flops.
    always_comb begin
        head_cell    = entries_q[head_q];
        rd_cell      = entries_q[rd_addr];
        // Admission looks only at the registered count, so a full buffer
        // refuses an alloc even while it commits in the same cycle.
        alloc_ready  = (count_q < FULL_COUNT);
        alloc_addr   = tail_q;
        commit_valid = (head_cell.state == ROB_STATE_RETIRED);
        commit_dest  = head_cell.dest;
        commit_value = head_cell.value;
        alloc_fire   = alloc_valid & alloc_ready;
        commit_fire  = commit_valid & commit_ready;
        rd_state     = rd_cell.state;
        rd_value     = rd_cell.value;
        count        = count_q;
        empty        = (count_q == '0);
    end

    // Next-state for entries, pointers and count; flush overrides everything.
    always_comb begin
        // NOTE: every combinational output gets a default up front so no path
        // leaves it unassigned, which would otherwise infer a latch.
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Issue only advances a PENDING entry.
            if (issue_valid && entries_q[issue_addr].state == ROB_STATE_PENDING) begin
                entries_d[issue_addr].state = ROB_STATE_EXECUTE;
            end

            // Writeback is applied after issue so it wins on a shared index.
            // The tail being allocated is still EMPTY in the registered
            // array, so a writeback aimed at it is dropped here.
            if (wb_valid &&
                (entries_q[wb_addr].state == ROB_STATE_PENDING ||
                 entries_q[wb_addr].state == ROB_STATE_EXECUTE)) begin
                entries_d[wb_addr].value = wb_value;
                entries_d[wb_addr].state = ROB_STATE_RETIRED;
            end

            // Commit frees the head; the head is RETIRED so no writeback
            // can touch it in the same cycle.
            if (commit_fire) begin
                entries_d[head_q] = '0;
                head_d            = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
            end

            // Alloc only when count < DEPTH, so the tail never aliases a
            // live head here.
            if (alloc_fire) begin
                entries_d[tail_q].value = '0;
                entries_d[tail_q].dest  = alloc_dest;
                entries_d[tail_q].state = ROB_STATE_PENDING;
                tail_d                  = (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Entry array, pointers and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry array is reset, not left uninitialised, because
            // a stale RETIRED state would raise commit_valid after release.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule : qu_rob

// File: tb/tb_qu_rob.sv
// Self-checking bench for qu_rob: directed scenarios plus randomized traffic,
// compared against an in-order queue model of the reorder buffer.
module tb_qu_rob;
    import qu_common::*;

    localparam int D = ROB_DEPTH;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         alloc_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] alloc_dest;
    logic                         alloc_ready;
    logic [ROB_ADDR_WIDTH-1:0]    alloc_addr;
    logic                         issue_valid;
    logic [ROB_ADDR_WIDTH-1:0]    issue_addr;
    logic                         wb_valid;
    logic [ROB_ADDR_WIDTH-1:0]    wb_addr;
    logic [31:0]                  wb_value;
    logic                         commit_valid;
    logic                         commit_ready;
    logic [PHY_RF_ADDR_WIDTH-1:0] commit_dest;
    logic [31:0]                  commit_value;
    logic [ROB_ADDR_WIDTH-1:0]    rd_addr;
    logic [1:0]                   rd_state;
    logic [31:0]                  rd_value;
    logic                         flush;
    logic [ROB_ADDR_WIDTH:0]      count;
    logic                         empty;

    qu_rob #(.DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_ready  (alloc_ready),
        .alloc_addr   (alloc_addr),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_value     (wb_value),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .rd_addr      (rd_addr),
        .rd_state     (rd_state),
        .rd_value     (rd_value),
        .flush        (flush),
        .count        (count),
        .empty        (empty)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: live entries in program order, oldest first.
    typedef struct {
        int          dest;
        int          st;   // 0 empty, 1 pending, 2 executing, 3 result ready
        logic [31:0] val;
    } ment_t;

    ment_t m_q[$];
    int    m_head = 0;

    function automatic int m_pos(input int idx);
        return (idx - m_head + D) % D;
    endfunction

    function automatic int m_state(input int idx);
        int p = m_pos(idx);
        return (p < m_q.size()) ? m_q[p].st : 0;
    endfunction

    function automatic logic [31:0] m_val(input int idx);
        int p = m_pos(idx);
        return (p < m_q.size()) ? m_q[p].val : 32'h0;
    endfunction

    function automatic int m_tail();
        return (m_head + m_q.size()) % D;
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_head = 0;
    endfunction

    function automatic void m_update(input logic av, input int ad, input logic iv, input int ia,
                                     input logic wv, input int wa, input logic [31:0] wd,
                                     input logic cr, input logic fl);
        bit    alloc_ok;
        bit    commit_ok;
        int    p;
        ment_t e;
        if (fl) begin
            m_reset();
            return;
        end
        alloc_ok  = av && (m_q.size() < D);
        commit_ok = cr && (m_q.size() > 0) && (m_q[0].st == 3);
        p = m_pos(ia);
        if (iv && p < m_q.size() && m_q[p].st == 1) m_q[p].st = 2;
        p = m_pos(wa);
        if (wv && p < m_q.size() && (m_q[p].st == 1 || m_q[p].st == 2)) begin
            m_q[p].st  = 3;
            m_q[p].val = wd;
        end
        if (commit_ok) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % D;
        end
        if (alloc_ok) begin
            e.dest = ad;
            e.st   = 1;
            e.val  = 32'h0;
            m_q.push_back(e);
        end
    endfunction

    // Compare every observable output against the model, sweeping rd_addr.
    task automatic check_outputs();
        bit exp_cv;
        int es;
        exp_cv = (m_q.size() > 0) && (m_q[0].st == 3);
        check("alloc_ready", alloc_ready, m_q.size() < D);
        check("alloc_addr", alloc_addr, m_tail());
        check("count", count, m_q.size());
        check("empty", empty, m_q.size() == 0);
        check("count_bound", count <= D, 1);
        check("commit_valid", commit_valid, exp_cv);
        if (exp_cv) begin
            check("commit_dest", commit_dest, m_q[0].dest);
            check("commit_value", commit_value, m_q[0].val);
        end
        for (int i = 0; i < D; i++) begin
            rd_addr = rob_addr_t'(i);
            #1;
            es = m_state(i);
            check($sformatf("rd_state[%0d]", i), rd_state, es);
            if (es != 0) check($sformatf("rd_value[%0d]", i), rd_value, m_val(i));
        end
    endtask

    task automatic drive_idle();
        alloc_valid  = 1'b0;
        alloc_dest   = '0;
        issue_valid  = 1'b0;
        issue_addr   = '0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        wb_value     = '0;
        commit_ready = 1'b0;
        flush        = 1'b0;
        rd_addr      = '0;
    endtask

    // One clock: drive at negedge, check pre-edge outputs, then step the model.
    task automatic step(input logic av, input int ad, input logic iv, input int ia,
                        input logic wv, input int wa, input logic [31:0] wd,
                        input logic cr, input logic fl);
        @(negedge clk);
        alloc_valid  = av;
        alloc_dest   = PHY_RF_ADDR_WIDTH'(ad);
        issue_valid  = iv;
        issue_addr   = rob_addr_t'(ia);
        wb_valid     = wv;
        wb_addr      = rob_addr_t'(wa);
        wb_value     = wd;
        commit_ready = cr;
        flush        = fl;
        #1;
        check_outputs();
        @(posedge clk);
        m_update(av, ad, iv, ia, wv, wa, wd, cr, fl);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Advance to the next negedge with idle inputs for explicit spot checks.
    task automatic peek();
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alloc_ready"}, alloc_ready, 1);
        check({tag, "_alloc_addr"}, alloc_addr, 0);
        check({tag, "_commit_valid"}, commit_valid, 0);
        check({tag, "_commit_dest"}, commit_dest, 0);
        check({tag, "_commit_value"}, commit_value, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_count"}, count, 0);
        check({tag, "_rd_state"}, rd_state, ROB_STATE_EMPTY);
        check({tag, "_rd_value"}, rd_value, 0);
    endtask

    int cyc;
    int wi;
    int k;

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #7;
        check_reset_outputs("por");
        #30;
        rst_n = 1'b1;
        m_reset();

        // Fill with commit_ready low: tails 0..7, then a ninth alloc is refused.
        for (int i = 0; i < D; i++) begin
            peek();
            check($sformatf("fill_addr%0d", i), alloc_addr, i);
            step(1, i + 1, 0, 0, 0, 0, 0, 0, 0);
        end
        peek();
        check("fill_count", count, 8);
        check("fill_ready", alloc_ready, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0);
        peek();
        check("fill_9th_refused", count, 8);

        // Full plus commit in the same cycle: no alloc taken, then tail wraps.
        step(0, 0, 0, 0, 1, 0, 32'hA5A5_0000, 0, 0);
        step(1, 20, 0, 0, 0, 0, 0, 1, 0);
        peek();
        check("full_commit_count", count, 7);
        check("full_commit_tail_wrap", alloc_addr, 0);
        step(1, 21, 0, 0, 0, 0, 0, 0, 0);
        peek();
        check("full_refill_count", count, 8);
        do_flush();

        // Out-of-order writeback: commit waits for index 0, then retires in order.
        step(1, 10, 0, 0, 0, 0, 0, 0, 0);
        step(1, 11, 0, 0, 0, 0, 0, 0, 0);
        step(1, 12, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 2, 32'hC, 1, 0);
        peek();
        check("ooo_wait2", commit_valid, 0);
        step(0, 0, 0, 0, 1, 1, 32'hB, 1, 0);
        peek();
        check("ooo_wait1", commit_valid, 0);
        step(0, 0, 0, 0, 1, 0, 32'hA, 1, 0);
        peek();
        check("ooo_cv0", commit_valid, 1);
        check("ooo_dest0", commit_dest, 10);
        check("ooo_val0", commit_value, 32'hA);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        peek();
        check("ooo_dest1", commit_dest, 11);
        check("ooo_val1", commit_value, 32'hB);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        peek();
        check("ooo_dest2", commit_dest, 12);
        check("ooo_val2", commit_value, 32'hC);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Wrap-around: alloc every cycle, retire the oldest unfinished entry, commit.
        for (int i = 0; i < 20; i++) begin
            wi = -1;
            for (k = 0; k < m_q.size(); k++) begin
                if (m_q[k].st != 3) begin
                    wi = (m_head + k) % D;
                    break;
                end
            end
            step(1, 30 + i, 0, 0, wi >= 0, (wi >= 0) ? wi : 0, $urandom, 1, 0);
        end
        idle();

        // Flush with five live entries while alloc and writeback are also asserted.
        do_flush();
        for (int i = 0; i < 5; i++) step(1, 40 + i, 0, 0, 0, 0, 0, 0, 0);
        step(1, 50, 0, 0, 1, 2, 32'hDEAD, 1, 1);
        peek();
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_alloc_addr", alloc_addr, 0);
        idle();

        // Asynchronous reset between edges with four retired entries.
        for (int i = 0; i < 4; i++) step(1, 60 + i, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i, 32'h100 + i, 0, 0);
        peek();
        check("pre_reset_cv", commit_valid, 1);
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        m_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        peek();
        check("post_reset_cv", commit_valid, 0);
        idle();

        // Randomized traffic.
        for (cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 63),
                 $urandom_range(0, 1), $urandom_range(0, D - 1),
                 $urandom_range(0, 1), $urandom_range(0, D - 1), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_qu_rob
